uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter between N_REQ requesters, e.g. the CPU control-register path and a debug/log source.
//  - Round-robin grant; latches the winner's byte and issues a one-cycle send to the UART.
//  - Tracks the UART ready handshake to completion, then pulses ack to the winning requester.
//  - Start timeout: if the UART never leaves ready after send, the transaction ends with ack + err so no requester can hang.
// PARAMETERS
//  N_REQ       2     number of requesters (2..8)
//  DATA_W      8     byte width sent to UART
//  START_TO    16    max cycles after send for uart_ready_i to deassert (>=2)
// PORTS
//  clk_i          in   1             system clock (10 MHz domain)
//  rst_i          in   1             asynchronous reset, active-low
//  req_i          in   N_REQ         level request per requester; held until ack
//  data_i         in   N_REQ*DATA_W  byte of requester k at [k*DATA_W +: DATA_W]
//  grant_o        out  N_REQ         one-hot owner of current transaction, 0 when idle
//  ack_o          out  N_REQ         one-cycle pulse to owner when transaction ends
//  err_o          out  1             one-cycle pulse with ack_o on start timeout
//  busy_o         out  1             1 in every state except IDLE
//  uart_data_o    out  DATA_W        latched byte presented to UART
//  uart_send_o    out  1             one-cycle send strobe to UART
//  uart_ready_i   in   1             UART ready: 1 = idle/done, 0 = transmitting
// BEHAVIOUR
//  Reset values (async, while rst_i=0)
//  - All outputs 0. State IDLE. RR pointer = N_REQ-1, so req 0 wins first.
//  - Reset mid-transaction drops it: no ack, no err.
//  Output timing
//  - All outputs are registers or state decodes.
//  - No combinational path from any input to any output.
//  FSM states: IDLE, SEND, WAIT_BUSY, WAIT_DONE, DONE
//  - IDLE: if any req_i set, pick the first set bit scanning ptr+1, ptr+2, ... modulo N_REQ.
//    - Register grant_o one-hot and uart_data_o = winner's byte.
//    - Load timeout counter = START_TO, go SEND. Otherwise stay.
//  - SEND: uart_send_o=1 for exactly this cycle, go WAIT_BUSY.
//  - WAIT_BUSY: if uart_ready_i==0, go WAIT_DONE.
//    - Else decrement the counter; at 0, set timeout flag and go DONE.
//  - WAIT_DONE: stay until uart_ready_i==1, then go DONE.
//    - No timeout in this state (frame length is UART-defined).
//  - DONE: ack_o[owner]=1 for one cycle; err_o=1 if timeout flag set.
//    - ptr <= owner, clear grant_o, clear timeout flag, go IDLE.
//  Latency
//  - req at IDLE edge t -> grant/uart_data valid and uart_send_o high in cycle t+1.
//  - ack one cycle after ready returns high.
//  - Minimum one IDLE cycle between transactions, so back-to-back grants are >=1 cycle apart.
//  Boundary conditions
//  - Simultaneous requests: strict RR. The owner just served has the lowest priority next.
//  - A single requester holding req is re-granted every transaction.
//  - req_i dropped after grant: the transaction still completes and ack is still pulsed.
//  - data_i changes after grant are ignored; the byte is latched in IDLE only.
//  - uart_ready_i low while IDLE: no effect. Arbitration does not wait for ready.
//    The UART must tolerate send only when ready.
//  - Pointer wrap: ptr = N_REQ-1 -> scan starts at 0.
//  - Counter width = clog2(START_TO+1); no overflow.
// TESTING
//  1. rst_i=0 mid-WAIT_DONE -> all outputs 0 next cycle, no ack.
//     After release, req_i=2'b11 -> grant_o=2'b01 first.
//  2. req_i=2'b01, data_i[7:0]=8'hA5; ready drops 2 cycles after send, rises 20 cycles later
//     -> send at t+1, uart_data_o=8'hA5, ack_o=2'b01 one cycle after the rise, err_o=0.
//  3. req_i=2'b11 held for 4 transactions -> grants 01,10,01,10; one ack per transaction.
//  4. ready_i stuck at 1 after send -> after START_TO=16 cycles in WAIT_BUSY:
//     ack_o[owner]=1 and err_o=1 together, then IDLE.
//  5. req_i[1] dropped after grant; data_i changed to 8'h00
//     -> still transmits the latched byte and pulses ack_o=2'b10.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between N_REQ requesters. A round-robin
//   arbiter picks a winner while idle and latches that requester's byte. It
//   then issues a single-cycle send strobe and follows the UART ready
//   handshake to completion. Finally it pulses ack to the winner. If the UART
//   never leaves ready after a send, a start timeout ends the transaction with
//   ack + err, so no requester can be left waiting forever.
//
// Parameters
//   N_REQ     number of requesters (2..8)
//   DATA_W    byte width presented to the UART
//   START_TO  cycles allowed after send for uart_ready_i to drop (>=2)
//
// Ports
//   clk_i         system clock
//   rst_i         asynchronous reset, active-low
//   req_i         level request per requester, held until ack
//   data_i        byte of requester k at [k*DATA_W +: DATA_W]
//   grant_o       one-hot owner of the current transaction, 0 when idle
//   ack_o         one-cycle pulse to the owner when the transaction ends
//   err_o         one-cycle pulse alongside ack_o on start timeout
//   busy_o        high in every state except IDLE
//   uart_data_o   latched byte presented to the UART
//   uart_send_o   one-cycle send strobe to the UART
//   uart_ready_i  UART ready: 1 = idle/done, 0 = transmitting

module uart_tx_arbiter #(
  parameter int N_REQ    = 2,
  parameter int DATA_W   = 8,
  parameter int START_TO = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*DATA_W-1:0]   data_i,
  output logic [N_REQ-1:0]          grant_o,
  output logic [N_REQ-1:0]          ack_o,
  output logic                      err_o,
  output logic                      busy_o,
  output logic [DATA_W-1:0]         uart_data_o,
  output logic                      uart_send_o,
  input  logic                      uart_ready_i
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(START_TO + 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_DONE,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   scan_idx;
  logic [N_REQ-1:0]   win_onehot;
  logic [DATA_W-1:0]  win_data;
  int                 scan;

  // Round-robin scan starting just after the last owner, so the requester
  // served most recently always has the lowest priority.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_data   = '0;
    scan       = 0;
    scan_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      scan     = (int'(ptr_q) + i) % N_REQ;
      scan_idx = scan[PTR_W-1:0];
      if (!win_found && req_i[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
        win_data  = data_i[scan*DATA_W +: DATA_W];
      end
    end
    win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_W'(N_REQ - 1);
      owner_q   <= '0;
      grant_q   <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // The byte is captured only in IDLE, so later changes on data_i or a
  // dropped request cannot disturb a transaction already in flight.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = win_onehot;
          data_d  = win_data;
          owner_d = win_idx;
          cnt_d   = CNT_W'(START_TO);
          state_d = SEND;
        end
      end
      SEND: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // The counter reaches zero on the START_TO-th cycle spent here.
        if (!uart_ready_i) begin
          state_d = WAIT_DONE;
        end else if (cnt_q <= CNT_W'(1)) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        // Frame length belongs to the UART, so there is no timeout here.
        if (uart_ready_i) begin
          state_d = DONE;
        end
      end
      DONE: begin
        ptr_d     = owner_q;
        grant_d   = '0;
        timeout_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Every output is a register or a decode of registered state, keeping
  // inputs off all output paths.
  assign grant_o     = grant_q;
  assign uart_data_o = data_q;
  assign uart_send_o = (state_q == SEND);
  assign busy_o      = (state_q != IDLE);
  assign ack_o       = (state_q == DONE) ? grant_q : '0;
  assign err_o       = (state_q == DONE) && timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Testbench for uart_tx_arbiter with N_REQ=2, DATA_W=8, START_TO=16. A
//   small UART model answers each send strobe. Expected sends and acks are
//   queued by the stimulus. A negedge monitor pops and compares them whenever
//   the DUT shows a send strobe or an ack/err pulse.

module tb_uart_tx_arbiter;

  localparam int N_REQ    = 2;
  localparam int DATA_W   = 8;
  localparam int START_TO = 16;

  typedef struct {
    logic [N_REQ-1:0]  grant;
    logic [DATA_W-1:0] data;
    int                send_cyc;
  } send_t;

  typedef struct {
    logic [N_REQ-1:0]  ack;
    logic              err;
    logic [DATA_W-1:0] data;
  } ack_t;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic [N_REQ-1:0]        req_i;
  logic [N_REQ*DATA_W-1:0] data_i;
  logic [N_REQ-1:0]        grant_o;
  logic [N_REQ-1:0]        ack_o;
  logic                    err_o;
  logic                    busy_o;
  logic [DATA_W-1:0]       uart_data_o;
  logic                    uart_send_o;
  logic                    uart_ready_i = 1'b1;

  int    cyc = 0;
  int    total = 0;
  int    bad = 0;
  int    drive_cyc = 0;
  int    last_send_cyc = -1;
  int    rise_cyc = -1;
  int    drop_delay = 2;
  int    busy_len = 20;
  int    wait_cnt = 0;
  int    busy_cnt = 0;
  bit    stuck = 1'b0;
  send_t send_q[$];
  ack_t  ack_q[$];
  send_t mon_s;
  ack_t  mon_a;

  uart_tx_arbiter #(
    .N_REQ   (N_REQ),
    .DATA_W  (DATA_W),
    .START_TO(START_TO)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .data_i      (data_i),
    .grant_o     (grant_o),
    .ack_o       (ack_o),
    .err_o       (err_o),
    .busy_o      (busy_o),
    .uart_data_o (uart_data_o),
    .uart_send_o (uart_send_o),
    .uart_ready_i(uart_ready_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // UART model: drop_delay cycles after a send strobe it goes busy, then
  // returns ready busy_len cycles later. While stuck it ignores sends.
  always @(posedge clk_i) begin
    #1;
    if (!rst_i) begin
      uart_ready_i = 1'b1;
      wait_cnt     = 0;
      busy_cnt     = 0;
    end else if (wait_cnt > 0) begin
      wait_cnt--;
      if (wait_cnt == 0) begin
        uart_ready_i = 1'b0;
        busy_cnt     = busy_len;
      end
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        uart_ready_i = 1'b1;
        rise_cyc     = cyc;
      end
    end else if (uart_send_o && !stuck) begin
      wait_cnt = drop_delay;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] r,
                               input logic [N_REQ*DATA_W-1:0] d);
    @(posedge clk_i);
    #1;
    req_i     = r;
    data_i    = d;
    drive_cyc = cyc;
  endtask

  task automatic pushSend(input logic [N_REQ-1:0] g, input logic [DATA_W-1:0] d,
                          input int sc);
    send_t s;
    s.grant    = g;
    s.data     = d;
    s.send_cyc = sc;
    send_q.push_back(s);
  endtask

  task automatic pushAck(input logic [N_REQ-1:0] a, input logic e,
                         input logic [DATA_W-1:0] d);
    ack_t x;
    x.ack  = a;
    x.err  = e;
    x.data = d;
    ack_q.push_back(x);
  endtask

  task automatic waitAck(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (ack_o == '0 && n < 200);
    checkOutput({name, " ack seen"}, 32'(|ack_o), 32'd1);
  endtask

  task automatic checkIdleGap();
    @(negedge clk_i);
    checkOutput("idle gap busy", 32'(busy_o), 32'd0);
    checkOutput("ack pulse width", 32'(ack_o), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " grant"}, 32'(grant_o), 32'd0);
    checkOutput({tag, " ack"}, 32'(ack_o), 32'd0);
    checkOutput({tag, " err"}, 32'(err_o), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy_o), 32'd0);
    checkOutput({tag, " send"}, 32'(uart_send_o), 32'd0);
    checkOutput({tag, " data"}, 32'(uart_data_o), 32'd0);
  endtask

  // Monitor: compares each send strobe and each ack/err pulse against the
  // oldest expectation in the matching queue.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (uart_send_o) begin
        if (send_q.size() == 0) begin
          checkOutput("unexpected send", 32'd1, 32'd0);
        end else begin
          mon_s = send_q.pop_front();
          checkOutput("send grant", 32'(grant_o), 32'(mon_s.grant));
          checkOutput("send byte", 32'(uart_data_o), 32'(mon_s.data));
          if (mon_s.send_cyc >= 0)
            checkOutput("send latency", cyc, mon_s.send_cyc);
          last_send_cyc = cyc;
        end
      end
      if (ack_o != '0 || err_o) begin
        if (ack_q.size() == 0) begin
          checkOutput("unexpected ack", 32'({ack_o, err_o}), 32'd0);
        end else begin
          mon_a = ack_q.pop_front();
          checkOutput("ack owner", 32'(ack_o), 32'(mon_a.ack));
          checkOutput("err flag", 32'(err_o), 32'(mon_a.err));
          checkOutput("latched byte at ack", 32'(uart_data_o), 32'(mon_a.data));
          if (mon_a.err)
            checkOutput("timeout ack timing", cyc, last_send_cyc + START_TO + 1);
          else
            checkOutput("ack timing", cyc, rise_cyc + 1);
        end
      end
    end
  end

  initial begin
    int n;
    rst_i  = 1'b0;
    req_i  = '0;
    data_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkAllZero("reset");
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    // Reset in the middle of WAIT_DONE drops the transaction silently.
    $display("[TB] reset during transfer");
    applyStimulus(2'b01, 16'h3377);
    pushSend(2'b01, 8'h77, drive_cyc + 1);
    n = 0;
    do begin
      @(posedge clk_i);
      n++;
    end while (uart_ready_i && n < 50);
    checkOutput("uart went busy", 32'(uart_ready_i), 32'd0);
    repeat (4) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    req_i = '0;
    @(negedge clk_i);
    checkAllZero("mid reset");
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    // After reset requester 0 wins a simultaneous request.
    applyStimulus(2'b11, 16'h2211);
    pushSend(2'b01, 8'h11, drive_cyc + 1);
    pushAck(2'b01, 1'b0, 8'h11);
    waitAck("post reset");
    req_i = '0;
    checkIdleGap();

    // Request dropped and data cleared after grant: latched byte still goes out.
    $display("[TB] drop request after grant");
    applyStimulus(2'b10, 16'h5C00);
    pushSend(2'b10, 8'h5C, drive_cyc + 1);
    pushAck(2'b10, 1'b0, 8'h5C);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (grant_o == '0 && n < 50);
    checkOutput("grant seen", 32'(grant_o), 32'd2);
    req_i  = '0;
    data_i = '0;
    waitAck("dropped req");
    checkIdleGap();

    // Both requesters held for four transactions alternate strictly.
    $display("[TB] round robin");
    applyStimulus(2'b11, 16'hB2A1);
    pushSend(2'b01, 8'hA1, drive_cyc + 1);
    pushSend(2'b10, 8'hB2, -1);
    pushSend(2'b01, 8'hA1, -1);
    pushSend(2'b10, 8'hB2, -1);
    pushAck(2'b01, 1'b0, 8'hA1);
    pushAck(2'b10, 1'b0, 8'hB2);
    pushAck(2'b01, 1'b0, 8'hA1);
    pushAck(2'b10, 1'b0, 8'hB2);
    for (int k = 0; k < 4; k++) begin
      waitAck("round robin");
      if (k == 3) req_i = '0;
      checkIdleGap();
    end

    // Single transfer with ready dropping 2 cycles after send, back 20 later.
    $display("[TB] single transfer");
    applyStimulus(2'b01, 16'h00A5);
    pushSend(2'b01, 8'hA5, drive_cyc + 1);
    pushAck(2'b01, 1'b0, 8'hA5);
    waitAck("single");
    req_i = '0;
    checkIdleGap();

    // UART ignores the send: start timeout ends it with ack + err.
    $display("[TB] start timeout");
    stuck = 1'b1;
    applyStimulus(2'b11, 16'h6699);
    pushSend(2'b10, 8'h66, drive_cyc + 1);
    pushAck(2'b10, 1'b1, 8'h66);
    waitAck("timeout");
    req_i = '0;
    stuck = 1'b0;
    checkIdleGap();

    checkOutput("send queue drained", 32'(send_q.size()), 32'd0);
    checkOutput("ack queue drained", 32'(ack_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
